pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 144 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush, per-lane operand forwarding and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NLANE     = 2,
    parameter int unsigned AUX_W     = 96,
    parameter int unsigned FLUSH_AUX = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NLANE*DATA_W-1:0] in_lane,
    input  logic [AUX_W-1:0]        in_aux,
    input  logic [NLANE-1:0]        fwd_sel,
    input  logic [NLANE*DATA_W-1:0] fwd_lane,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NLANE*DATA_W-1:0] out_lane,
    output logic [AUX_W-1:0]        out_aux,
    output logic [15:0]             stall_cnt
);

    logic                    r_valid;
    logic [CTRL_W-1:0]       r_ctrl;
    logic [NLANE*DATA_W-1:0] r_lane;
    logic [AUX_W-1:0]        r_aux;
    logic [15:0]             r_stall_cnt;

    logic                    w_accept;
    logic                    w_stall;
    logic [NLANE*DATA_W-1:0] w_lane_sel;

    // Forwarding override is applied per lane on the incoming beat only.
    always_comb begin
        w_lane_sel = in_lane;
        for (int i = 0; i < int'(NLANE); i++) begin
            if (fwd_sel[i]) begin
                w_lane_sel[i*DATA_W +: DATA_W] = fwd_lane[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_accept = in_valid && in_ready;
    assign w_stall  = r_valid && !out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                    r_skid_valid;
    logic [CTRL_W-1:0]       r_skid_ctrl;
    logic [NLANE*DATA_W-1:0] r_skid_lane;
    logic [AUX_W-1:0]        r_skid_aux;

    assign in_ready = !r_skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_lane       <= '0;
            r_aux        <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_lane  <= '0;
            r_skid_aux   <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            if (FLUSH_AUX != 0) begin
                r_aux <= '0;
            end
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else if (!r_valid || out_ready) begin
            // Output slot frees up: skid content always goes first.
            if (r_skid_valid) begin
                r_valid      <= 1'b1;
                r_ctrl       <= r_skid_ctrl;
                r_lane       <= r_skid_lane;
                r_aux        <= r_skid_aux;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_ctrl  <= in_ctrl;
                r_lane  <= w_lane_sel;
                r_aux   <= in_aux;
            end else begin
                r_valid <= 1'b0;
                r_ctrl  <= '0;
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= in_ctrl;
            r_skid_lane  <= w_lane_sel;
            r_skid_aux   <= in_aux;
        end
    end
`else
    assign in_ready = out_ready || !r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_lane  <= '0;
            r_aux   <= '0;
        end else if (flush) begin
            // Lanes are kept so forwarded operands survive the kill.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            if (FLUSH_AUX != 0) begin
                r_aux <= '0;
            end
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ctrl  <= in_ctrl;
            r_lane  <= w_lane_sel;
            r_aux   <= in_aux;
        end else if (out_ready) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign out_valid = r_valid;
    assign out_ctrl  = r_ctrl;
    assign out_lane  = r_lane;
    assign out_aux   = r_aux;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; a second instance with FLUSH_AUX=0 checks aux retention.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_ctrl;
    logic [63:0] in_lane;
    logic [95:0] in_aux;
    logic [1:0]  fwd_sel;
    logic [63:0] fwd_lane;

    logic        in_ready, out_valid;
    logic [15:0] out_ctrl, stall_cnt;
    logic [63:0] out_lane;
    logic [95:0] out_aux;

    logic        k_in_ready, k_out_valid;
    logic [15:0] k_out_ctrl, k_stall_cnt;
    logic [63:0] k_out_lane;
    logic [95:0] k_out_aux;

    int n_vec = 0;
    int n_bad = 0;

    localparam logic [95:0] AuxA = 96'h0000_1000_0000_0ABC_0000_1004;
    localparam logic [95:0] AuxD = 96'h0000_2000_0000_0D00_0000_2004;
    localparam logic [95:0] AuxG = 96'h0000_3000_0000_0600_0000_3004;

    pipe_stage_reg u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_lane   (in_lane),
        .in_aux    (in_aux),
        .fwd_sel   (fwd_sel),
        .fwd_lane  (fwd_lane),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_lane  (out_lane),
        .out_aux   (out_aux),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.FLUSH_AUX(0)) u_dut_keep (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (k_in_ready),
        .in_ctrl   (in_ctrl),
        .in_lane   (in_lane),
        .in_aux    (in_aux),
        .fwd_sel   (fwd_sel),
        .fwd_lane  (fwd_lane),
        .out_valid (k_out_valid),
        .out_ready (out_ready),
        .out_ctrl  (k_out_ctrl),
        .out_lane  (k_out_lane),
        .out_aux   (k_out_aux),
        .stall_cnt (k_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] c, input logic [63:0] l, input logic [95:0] a);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_lane  = l;
        in_aux   = a;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_lane = '0; in_aux = '0; fwd_sel = '0; fwd_lane = '0;
        step();
        step();
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_ctrl", out_ctrl, 0);
        check_eq("rst_lane", out_lane, 0);
        check_eq("rst_aux", out_aux, 0);
        check_eq("rst_stall", stall_cnt, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1);

        // Basic load, one-cycle latency
        out_ready = 1'b1;
        drive(16'h00A5, {32'h22, 32'h11}, AuxA);
        step();
        in_valid = 1'b0;
        check_eq("ld_valid", out_valid, 1);
        check_eq("ld_ctrl", out_ctrl, 16'h00A5);
        check_eq("ld_lane", out_lane, {32'h22, 32'h11});
        check_eq("ld_aux", out_aux, AuxA);
        step();
        check_eq("bubble_valid", out_valid, 0);
        check_eq("bubble_ctrl", out_ctrl, 0);

        // Forwarding on lane 0, then lane 1
        fwd_sel = 2'b01; fwd_lane = {32'hBEEF, 32'hDEAD};
        drive(16'h0102, {32'h33, 32'h11}, AuxA);
        step();
        check_eq("fwd0_lane", out_lane, {32'h33, 32'hDEAD});
        fwd_sel = 2'b10; fwd_lane = {32'hBEEF, 32'hCAFE};
        drive(16'h0103, {32'h55, 32'h44}, AuxA);
        step();
        in_valid = 1'b0;
        check_eq("fwd1_lane", out_lane, {32'hBEEF, 32'h44});
        check_eq("replace_valid", out_valid, 1);
        check_eq("replace_ctrl", out_ctrl, 16'h0103);
        fwd_sel = 2'b11; fwd_lane = {32'h9999, 32'h8888};
        step();
        check_eq("fwd_not_accept_lane", out_lane, {32'hBEEF, 32'h44});
        fwd_sel = 2'b00;

        // Backpressure: 5 stall cycles with beat A held
        drive(16'h0033, {32'h66, 32'h77}, AuxA);
        step();
        out_ready = 1'b0;
        drive(16'h0044, {32'h88, 32'h99}, AuxD);
        #1;
`ifdef PIPE_STAGE_SKID_EN
        check_eq("stall_in_ready0", in_ready, 1);
`else
        check_eq("stall_in_ready0", in_ready, 0);
`endif
        step();
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 1'b0;
`endif
        check_eq("stall_in_ready1", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("stall_hold_ctrl", out_ctrl, 16'h0033);
        end
        check_eq("stall_hold_valid", out_valid, 1);
        check_eq("stall_hold_lane", out_lane, {32'h66, 32'h77});
        check_eq("stall_hold_aux", out_aux, AuxA);
        check_eq("stall_cnt5", stall_cnt, 5);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("release_ctrl", out_ctrl, 16'h0044);
        check_eq("release_lane", out_lane, {32'h88, 32'h99});
        step();
        check_eq("drain_valid", out_valid, 0);

        // Flush while a beat is held, with a new beat offered
        drive(16'h00D1, {32'hD2, 32'hD1}, AuxD);
        step();
        out_ready = 1'b0;
        flush = 1'b1;
        drive(16'h00E1, {32'hE2, 32'hE1}, AuxG);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_ctrl", out_ctrl, 0);
        check_eq("flush_aux", out_aux, 0);
        check_eq("flush_lane", out_lane, {32'hD2, 32'hD1});
        check_eq("flush_keep_aux", k_out_aux, AuxD);
        check_eq("flush_stall", stall_cnt, 6);
        step();
        check_eq("flush_lost_valid", out_valid, 0);

        // Flush drops a beat accepted in the same cycle
        flush = 1'b1;
        drive(16'h00F1, {32'hF2, 32'hF1}, AuxG);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_acc_valid", out_valid, 0);
        check_eq("flush_acc_lane", out_lane, {32'hD2, 32'hD1});
        check_eq("flush_acc_ctrl", out_ctrl, 0);

        // Saturation over 70000 stall cycles
        drive(16'h0077, {32'h1, 32'h2}, AuxG);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        check_eq("stall_sat", stall_cnt, 16'hFFFF);

        // Reset beats flush and load
        rst = 1'b1; flush = 1'b1;
        drive(16'h0088, {32'h3, 32'h4}, AuxA);
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        check_eq("rstf_valid", out_valid, 0);
        check_eq("rstf_ctrl", out_ctrl, 0);
        check_eq("rstf_lane", out_lane, 0);
        check_eq("rstf_aux", out_aux, 0);
        check_eq("rstf_stall", stall_cnt, 0);
        check_eq("rstf_keep_aux", k_out_aux, 0);
        check_eq("rstf_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
